// File: rtl/dpd_pkg.sv
// Shared widths, fixed-point constants and the complex word type for the DPD
// polynomial apply stage.
package dpd_pkg;

  localparam int unsigned W         = 20;
  localparam int unsigned N_TERMS   = 5;
  localparam int unsigned MAG_FRAC  = 19;
  localparam int unsigned COEF_FRAC = 18;

  localparam int unsigned PROD1_W = 2 * W + 1;
  localparam int unsigned SUM_W   = 44;
  localparam int unsigned PROD2_W = 2 * W;
  localparam int unsigned MIX_W   = PROD2_W + 1;

  localparam int COEF_ONE = 262144;
  localparam int SAT_MAX  = 524287;
  localparam int SAT_MIN  = -524288;

  typedef struct packed {
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
  } cplx_t;

  localparam cplx_t COEF_IDENT = '{i: W'(COEF_ONE), q: '0};

  // Identity polynomial: a_0 = 1.0, all higher terms zero.
  function automatic cplx_t coef_reset_val(input int k);
    return (k == 0) ? COEF_IDENT : cplx_t'('0);
  endfunction

endpackage

// File: rtl/dpd_round_sat.sv
// Arithmetic right shift with round-half-up, then clamp to the signed output
// range; o_ovf_c flags a clamp.
module dpd_round_sat
  import dpd_pkg::*;
#(
  parameter int unsigned IN_W  = 44,
  parameter int unsigned SHIFT = 19,
  parameter int unsigned OUT_W = dpd_pkg::W
) (
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [OUT_W-1:0] o_data_c,
  output logic                    o_ovf_c
);

  localparam int unsigned EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(1) <<< (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(SAT_MAX);
  localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(SAT_MIN);

  logic signed [EXT_W-1:0] w_rnd;
  logic signed [EXT_W-1:0] w_shr;

  // One guard bit keeps the rounding add from wrapping.
  assign w_rnd = EXT_W'(i_data) + HALF;
  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    o_ovf_c  = 1'b0;
    o_data_c = w_shr[OUT_W-1:0];
    if (w_shr > MAX_V) begin
      o_ovf_c  = 1'b1;
      o_data_c = OUT_W'(SAT_MAX);
    end else if (w_shr < MIN_V) begin
      o_ovf_c  = 1'b1;
      o_data_c = OUT_W'(SAT_MIN);
    end
  end

endmodule

// File: rtl/dpd_poly_apply.sv
// Applies y = x * sum(a_k * |x|^k) with a double-buffered coefficient bank;
// five-stage pipeline from the magnitude inputs, optional bypass per sample.
module dpd_poly_apply
  import dpd_pkg::*;
#(
  parameter int unsigned IQ_DELAY = 6,
  parameter int unsigned W        = dpd_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] sig_in_i,
  input  logic [W-1:0] sig_in_q,
  input  logic [W-1:0] mag_0,
  input  logic [W-1:0] mag_1,
  input  logic [W-1:0] mag_2,
  input  logic [W-1:0] mag_3,
  input  logic [W-1:0] mag_4,
  input  logic         dpd_en,
  input  logic         coef_wr_en,
  input  logic [2:0]   coef_addr,
  input  logic [W-1:0] coef_wdata_i,
  input  logic [W-1:0] coef_wdata_q,
  input  logic         coef_commit,
  input  logic         sat_clr,
  output logic         out_valid,
  output logic [W-1:0] sig_out_i,
  output logic [W-1:0] sig_out_q,
  output logic         sat_flag
);

  cplx_t r_xd [IQ_DELAY];
  cplx_t r_shadow [N_TERMS];
  cplx_t r_active [N_TERMS];
  cplx_t w_shadow_nxt [N_TERMS];
  cplx_t r_x [4];
  logic [W-1:0] w_mag [N_TERMS];
  logic [3:0] r_vld;
  logic [3:0] r_en;

  logic signed [PROD1_W-1:0] r_p_i [N_TERMS];
  logic signed [PROD1_W-1:0] r_p_q [N_TERMS];
  logic signed [SUM_W-1:0]   w_sum_i, w_sum_q, r_s_i, r_s_q;
  logic signed [W-1:0]       w_g_i, w_g_q, r_g_i, r_g_q;
  logic                      w_g_i_ovf, w_g_q_ovf;
  logic signed [PROD2_W-1:0] r_m_ii, r_m_qq, r_m_iq, r_m_qi;
  logic signed [MIX_W-1:0]   w_mix_i, w_mix_q;
  logic signed [W-1:0]       w_y_i, w_y_q;
  logic                      w_y_i_ovf, w_y_q_ovf;
  logic                      w_sat_set;

  assign w_mag[0] = mag_0;
  assign w_mag[1] = mag_1;
  assign w_mag[2] = mag_2;
  assign w_mag[3] = mag_3;
  assign w_mag[4] = mag_4;

  // Delay x so it meets its own magnitude terms at S1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(IQ_DELAY); k++) r_xd[k] <= '0;
    end else begin
      r_xd[0] <= '{i: sig_in_i, q: sig_in_q};
      for (int k = 1; k < int'(IQ_DELAY); k++) r_xd[k] <= r_xd[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(N_TERMS); k++) begin
      w_shadow_nxt[k] = r_shadow[k];
      if (coef_wr_en && (coef_addr == 3'(k))) begin
        w_shadow_nxt[k] = '{i: coef_wdata_i, q: coef_wdata_q};
      end
    end
  end

  // Commit copies the shadow bank including a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(N_TERMS); k++) begin
        r_shadow[k] <= coef_reset_val(k);
        r_active[k] <= coef_reset_val(k);
      end
    end else begin
      for (int k = 0; k < int'(N_TERMS); k++) begin
        r_shadow[k] <= w_shadow_nxt[k];
        if (coef_commit) r_active[k] <= w_shadow_nxt[k];
      end
    end
  end

  // S1: basis-by-coefficient products; x, valid and enable travel alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(N_TERMS); k++) begin
        r_p_i[k] <= '0;
        r_p_q[k] <= '0;
      end
      for (int k = 0; k < 4; k++) r_x[k] <= '0;
      r_vld <= '0;
      r_en  <= '0;
    end else begin
      for (int k = 0; k < int'(N_TERMS); k++) begin
        r_p_i[k] <= PROD1_W'($signed({1'b0, w_mag[k]})) * PROD1_W'($signed(r_active[k].i));
        r_p_q[k] <= PROD1_W'($signed({1'b0, w_mag[k]})) * PROD1_W'($signed(r_active[k].q));
      end
      r_x[0] <= r_xd[IQ_DELAY-1];
      for (int k = 1; k < 4; k++) r_x[k] <= r_x[k-1];
      r_vld <= {r_vld[2:0], in_valid};
      r_en  <= {r_en[2:0], dpd_en};
    end
  end

  always_comb begin
    w_sum_i = '0;
    w_sum_q = '0;
    for (int k = 0; k < int'(N_TERMS); k++) begin
      w_sum_i = w_sum_i + SUM_W'(r_p_i[k]);
      w_sum_q = w_sum_q + SUM_W'(r_p_q[k]);
    end
  end

  dpd_round_sat #(.IN_W(SUM_W), .SHIFT(MAG_FRAC), .OUT_W(W)) u_gain_i (
    .i_data(r_s_i), .o_data_c(w_g_i), .o_ovf_c(w_g_i_ovf)
  );
  dpd_round_sat #(.IN_W(SUM_W), .SHIFT(MAG_FRAC), .OUT_W(W)) u_gain_q (
    .i_data(r_s_q), .o_data_c(w_g_q), .o_ovf_c(w_g_q_ovf)
  );

  assign w_mix_i = MIX_W'(r_m_ii) - MIX_W'(r_m_qq);
  assign w_mix_q = MIX_W'(r_m_iq) + MIX_W'(r_m_qi);

  dpd_round_sat #(.IN_W(MIX_W), .SHIFT(COEF_FRAC), .OUT_W(W)) u_out_i (
    .i_data(w_mix_i), .o_data_c(w_y_i), .o_ovf_c(w_y_i_ovf)
  );
  dpd_round_sat #(.IN_W(MIX_W), .SHIFT(COEF_FRAC), .OUT_W(W)) u_out_q (
    .i_data(w_mix_q), .o_data_c(w_y_q), .o_ovf_c(w_y_q_ovf)
  );

  // S2 sums, S3 gain, S4 complex products, S5 output select.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_i     <= '0;
      r_s_q     <= '0;
      r_g_i     <= '0;
      r_g_q     <= '0;
      r_m_ii    <= '0;
      r_m_qq    <= '0;
      r_m_iq    <= '0;
      r_m_qi    <= '0;
      out_valid <= 1'b0;
      sig_out_i <= '0;
      sig_out_q <= '0;
    end else begin
      r_s_i     <= w_sum_i;
      r_s_q     <= w_sum_q;
      r_g_i     <= w_g_i;
      r_g_q     <= w_g_q;
      r_m_ii    <= PROD2_W'($signed(r_x[2].i)) * PROD2_W'(r_g_i);
      r_m_qq    <= PROD2_W'($signed(r_x[2].q)) * PROD2_W'(r_g_q);
      r_m_iq    <= PROD2_W'($signed(r_x[2].i)) * PROD2_W'(r_g_q);
      r_m_qi    <= PROD2_W'($signed(r_x[2].q)) * PROD2_W'(r_g_i);
      out_valid <= r_vld[3];
      sig_out_i <= r_en[3] ? w_y_i : r_x[3].i;
      sig_out_q <= r_en[3] ? w_y_q : r_x[3].q;
    end
  end

  // Bypassed samples never raise the flag; a new clamp beats a clear.
  assign w_sat_set = (r_vld[1] && r_en[1] && (w_g_i_ovf || w_g_q_ovf)) ||
                     (r_vld[3] && r_en[3] && (w_y_i_ovf || w_y_q_ovf));

  always_ff @(posedge clk) begin
    if (reset)          sat_flag <= 1'b0;
    else if (w_sat_set) sat_flag <= 1'b1;
    else if (sat_clr)   sat_flag <= 1'b0;
  end

endmodule

// File: tb/tb_dpd_poly_apply.sv
// Directed bench for dpd_poly_apply: identity, gain term, commit timing,
// saturation, bypass toggling and mid-stream reset.
module tb_dpd_poly_apply;

  localparam int IQ = 6;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [19:0] sig_in_i, sig_in_q;
  logic [19:0] mag_0, mag_1, mag_2, mag_3, mag_4;
  logic        dpd_en;
  logic        coef_wr_en;
  logic [2:0]  coef_addr;
  logic [19:0] coef_wdata_i, coef_wdata_q;
  logic        coef_commit;
  logic        sat_clr;
  logic        out_valid;
  logic [19:0] sig_out_i, sig_out_q;
  logic        sat_flag;

  logic [19:0] xi_at [0:511];
  logic [19:0] xq_at [0:511];
  int cyc;
  int n_checks;
  int n_errors;

  dpd_poly_apply #(.IQ_DELAY(IQ), .W(20)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .sig_in_i(sig_in_i), .sig_in_q(sig_in_q),
    .mag_0(mag_0), .mag_1(mag_1), .mag_2(mag_2), .mag_3(mag_3), .mag_4(mag_4),
    .dpd_en(dpd_en), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
    .coef_wdata_i(coef_wdata_i), .coef_wdata_q(coef_wdata_q),
    .coef_commit(coef_commit), .sat_clr(sat_clr),
    .out_valid(out_valid), .sig_out_i(sig_out_i), .sig_out_q(sig_out_q),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    sig_in_i = xi_at[cyc];
    sig_in_q = xq_at[cyc];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic plan_x(input int k, input int xi, input int xq);
    xi_at[cyc+k] = 20'(xi);
    xq_at[cyc+k] = 20'(xq);
  endtask

  task automatic set_mag(input int m0, input int m1, input int m2, input int m3,
                         input int m4, input logic en);
    mag_0 = 20'(m0); mag_1 = 20'(m1); mag_2 = 20'(m2); mag_3 = 20'(m3); mag_4 = 20'(m4);
    in_valid = 1'b1;
    dpd_en   = en;
  endtask

  task automatic idle();
    mag_0 = '0; mag_1 = '0; mag_2 = '0; mag_3 = '0; mag_4 = '0;
    in_valid = 1'b0;
    dpd_en   = 1'b1;
  endtask

  task automatic wr_coef(input int addr, input int ci, input int cq, input logic commit);
    coef_wr_en   = 1'b1;
    coef_addr    = 3'(addr);
    coef_wdata_i = 20'(ci);
    coef_wdata_q = 20'(cq);
    coef_commit  = commit;
  endtask

  task automatic chk20(input string tag, input logic [19:0] obs, input int exp);
    logic [19:0] e;
    e = 20'(exp);
    n_checks++;
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(e));
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int rnd_mag();
    return int'($urandom_range(0, 524287));
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) begin
      xi_at[i] = '0;
      xq_at[i] = '0;
    end
    cyc = 0; n_checks = 0; n_errors = 0;
    reset = 1'b1; sat_clr = 1'b0;
    coef_wr_en = 1'b0; coef_addr = '0; coef_wdata_i = '0; coef_wdata_q = '0; coef_commit = 1'b0;
    sig_in_i = '0; sig_in_q = '0;
    idle();

    // Reset state
    repeat (3) step();
    chk1("rst_valid", out_valid, 1'b0);
    chk20("rst_out_i", sig_out_i, 0);
    chk20("rst_out_q", sig_out_q, 0);
    chk1("rst_sat", sat_flag, 1'b0);
    reset = 1'b0;
    step();

    // Identity bank: output equals x exactly, 5 cycles after the mag sample
    plan_x(0, 262144, -131072);
    repeat (IQ) step();
    set_mag(524287, rnd_mag(), rnd_mag(), rnd_mag(), rnd_mag(), 1'b1);
    step(); idle();
    repeat (3) step();
    chk1("id_not_early", out_valid, 1'b0);
    step();
    chk1("id_valid", out_valid, 1'b1);
    chk20("id_out_i", sig_out_i, 262144);
    chk20("id_out_q", sig_out_q, -131072);
    step();
    chk1("id_single", out_valid, 1'b0);

    // a_1 = 0.5, |x| = 0.5 -> gain 1.25
    wr_coef(1, 131072, 0, 1'b0); step();
    coef_wr_en = 1'b0; coef_commit = 1'b1; step();
    coef_commit = 1'b0;
    plan_x(0, 262144, 0);
    repeat (IQ) step();
    set_mag(524287, 262144, rnd_mag(), rnd_mag(), rnd_mag(), 1'b1);
    step(); idle();
    repeat (4) step();
    chk1("a1_valid", out_valid, 1'b1);
    chk20("a1_out_i", sig_out_i, 327680);
    chk20("a1_out_q", sig_out_q, 0);
    chk1("a1_sat", sat_flag, 1'b0);

    // Write+commit a_0 = j alongside sample A; A keeps the old bank, B gets j
    plan_x(0, 100000, -50000);
    plan_x(1, -200000, 150000);
    repeat (IQ) step();
    set_mag(524287, 0, rnd_mag(), rnd_mag(), rnd_mag(), 1'b1);
    wr_coef(0, 0, 262144, 1'b1);
    step();
    coef_wr_en = 1'b0; coef_commit = 1'b0;
    set_mag(524287, 0, rnd_mag(), rnd_mag(), rnd_mag(), 1'b1);
    step(); idle();
    repeat (3) step();
    chk1("cm_a_valid", out_valid, 1'b1);
    chk20("cm_a_out_i", sig_out_i, 100000);
    chk20("cm_a_out_q", sig_out_q, -50000);
    step();
    chk1("cm_b_valid", out_valid, 1'b1);
    chk20("cm_b_out_i", sig_out_i, -150000);
    chk20("cm_b_out_q", sig_out_q, -200000);

    // Gain ~(2,2) on x ~(1,1): Q output clamps, flag is sticky until cleared
    wr_coef(0, 524287, 524287, 1'b1); step();
    coef_wr_en = 1'b0; coef_commit = 1'b0;
    plan_x(0, 524287, 524287);
    repeat (IQ) step();
    set_mag(524287, 0, 0, 0, 0, 1'b1);
    step(); idle();
    repeat (3) step();
    chk1("sat_not_early", sat_flag, 1'b0);
    step();
    chk20("sat_out_i", sig_out_i, 0);
    chk20("sat_out_q", sig_out_q, 524287);
    chk1("sat_set", sat_flag, 1'b1);
    step();
    chk1("sat_sticky", sat_flag, 1'b1);
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    chk1("sat_cleared", sat_flag, 1'b0);

    // dpd_en 1,0,1 on consecutive samples with a_0 = j
    wr_coef(0, 0, 262144, 1'b1); step();
    coef_wr_en = 1'b0; coef_commit = 1'b0;
    plan_x(0, 10000, 20000);
    plan_x(1, -30000, 40000);
    plan_x(2, 50000, -60000);
    repeat (IQ) step();
    set_mag(524287, 0, 0, 0, 0, 1'b1); step();
    set_mag(524287, 0, 0, 0, 0, 1'b0); step();
    set_mag(524287, 0, 0, 0, 0, 1'b1); step();
    idle();
    repeat (2) step();
    chk1("en0_valid", out_valid, 1'b1);
    chk20("en0_out_i", sig_out_i, -20000);
    chk20("en0_out_q", sig_out_q, 10000);
    step();
    chk1("byp_valid", out_valid, 1'b1);
    chk20("byp_out_i", sig_out_i, -30000);
    chk20("byp_out_q", sig_out_q, 40000);
    step();
    chk1("en2_valid", out_valid, 1'b1);
    chk20("en2_out_i", sig_out_i, 60000);
    chk20("en2_out_q", sig_out_q, 50000);
    step();
    chk1("en_end_valid", out_valid, 1'b0);
    chk1("en_sat", sat_flag, 1'b0);

    // Reset mid-stream with a write to address 6
    for (int k = 0; k < 6; k++) plan_x(k, 70000 + k * 1000, -30000);
    repeat (IQ) step();
    for (int k = 0; k < 5; k++) begin
      set_mag(524287, 0, 0, 0, 0, 1'b1);
      step();
    end
    chk1("pre_rst_valid", out_valid, 1'b1);
    chk20("pre_rst_out_i", sig_out_i, 30000);
    chk20("pre_rst_out_q", sig_out_q, 70000);
    reset = 1'b1;
    wr_coef(6, 131072, 131072, 1'b0);
    step();
    reset = 1'b0; coef_wr_en = 1'b0; idle();
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk20("mid_rst_out_i", sig_out_i, 0);
    chk20("mid_rst_out_q", sig_out_q, 0);
    repeat (5) step();
    chk1("flushed_valid", out_valid, 1'b0);
    wr_coef(6, 131072, 131072, 1'b1); step();
    coef_wr_en = 1'b0; coef_commit = 1'b0;
    plan_x(0, 300000, -250000);
    repeat (IQ) step();
    set_mag(524287, 200000, 300000, 400000, 100000, 1'b1);
    step(); idle();
    repeat (4) step();
    chk1("post_rst_valid", out_valid, 1'b1);
    chk20("post_rst_out_i", sig_out_i, 300000);
    chk20("post_rst_out_q", sig_out_q, -250000);
    chk1("post_rst_sat", sat_flag, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
